// File: rtl/timer_bank.sv
// rtl/timer_bank.sv - bank of NUM_CH independent prescaled down-counting timers
// Ports:
//   clk        : clock
//   reset      : synchronous, active-high reset
//   addr       : word address, [CH_BITS+1:2] channel, [1:0] register
//   we         : register write strobe
//   write_data : register write data
//   read_data  : combinational read of the addressed register
//   irq        : per-channel interrupt, PEND & IM
module timer_bank #(
  parameter int NUM_CH    = 2,
  parameter int CNT_WIDTH = 32,
  parameter int CH_BITS   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [CH_BITS+1:0] addr,
  input  logic               we,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic [NUM_CH-1:0]  irq
);

  localparam logic [1:0] REG_CTRL     = 2'd0;
  localparam logic [1:0] REG_PRESET   = 2'd1;
  localparam logic [1:0] REG_COUNT    = 2'd2;
  localparam logic [1:0] REG_PRESCALE = 2'd3;

  // S_PAUSE is the idle state entered by disabling mid-count; a later EN=1
  // write resumes counting from the frozen value instead of reloading.
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_PAUSE} state_e;

  state_e                              state_q [NUM_CH];
  state_e                              state_d [NUM_CH];
  logic [NUM_CH-1:0]                   en_q, en_d;
  logic [NUM_CH-1:0][1:0]              mode_q, mode_d;
  logic [NUM_CH-1:0]                   im_q, im_d;
  logic [NUM_CH-1:0]                   pend_q, pend_d;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0]    preset_q, preset_d;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0]    count_q, count_d;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0]    prescale_q, prescale_d;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0]    pcnt_q, pcnt_d;

  logic [NUM_CH-1:0]                   ch_wr;
  logic [NUM_CH-1:0]                   expire;

  // Channel indices >= NUM_CH never match, so out-of-range writes are dropped
  // and out-of-range reads fall through to zero.
  always_comb begin
    ch_wr  = '0;
    expire = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ch_wr[c]  = we && (addr[CH_BITS+1:2] == CH_BITS'(c));
      // Expiry waits for a prescaler tick with COUNT already at zero.
      expire[c] = (state_q[c] == S_CNT) && (pcnt_q[c] == prescale_q[c]) &&
                  (count_q[c] == '0);
    end
  end

  always_comb begin
    en_d       = en_q;
    mode_d     = mode_q;
    im_d       = im_q;
    pend_d     = pend_q;
    preset_d   = preset_q;
    count_d    = count_q;
    prescale_d = prescale_q;
    pcnt_d     = pcnt_q;
    for (int c = 0; c < NUM_CH; c++) begin
      state_d[c] = state_q[c];

      case (state_q[c])
        S_LOAD: begin
          count_d[c] = preset_q[c];
          pcnt_d[c]  = '0;
          state_d[c] = S_CNT;
        end
        S_CNT: begin
          if (pcnt_q[c] == prescale_q[c]) begin
            pcnt_d[c] = '0;
            if (count_q[c] != '0) count_d[c] = count_q[c] - 1'b1;
          end else begin
            pcnt_d[c] = pcnt_q[c] + 1'b1;
          end
        end
        default: ;
      endcase

      if (expire[c]) begin
        pend_d[c] = 1'b1;
        if (mode_q[c] == 2'b01) begin
          state_d[c] = S_LOAD;
        end else begin
          en_d[c]    = 1'b0;
          state_d[c] = S_IDLE;
        end
      end

      if (ch_wr[c]) begin
        case (addr[1:0])
          REG_CTRL: begin
            mode_d[c] = write_data[2:1];
            im_d[c]   = write_data[3];
            // Write-1-to-clear loses against a same-cycle expiry.
            if (write_data[4]) pend_d[c] = expire[c];
            if (!write_data[0]) begin
              en_d[c]    = 1'b0;
              count_d[c] = count_q[c];
              pcnt_d[c]  = pcnt_q[c];
              state_d[c] = ((state_q[c] == S_CNT && !expire[c]) ||
                            state_q[c] == S_PAUSE) ? S_PAUSE : S_IDLE;
            end else if (write_data[5] || state_q[c] == S_IDLE) begin
              en_d[c]    = 1'b1;
              state_d[c] = S_LOAD;
            end else if (state_q[c] == S_PAUSE) begin
              en_d[c]    = 1'b1;
              state_d[c] = S_CNT;
            end
          end
          REG_PRESET:   preset_d[c]   = write_data[CNT_WIDTH-1:0];
          REG_PRESCALE: prescale_d[c] = write_data[CNT_WIDTH-1:0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q       <= '0;
      mode_q     <= '0;
      im_q       <= '0;
      pend_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      prescale_q <= '0;
      pcnt_q     <= '0;
      for (int c = 0; c < NUM_CH; c++) state_q[c] <= S_IDLE;
    end else begin
      en_q       <= en_d;
      mode_q     <= mode_d;
      im_q       <= im_d;
      pend_q     <= pend_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
      for (int c = 0; c < NUM_CH; c++) state_q[c] <= state_d[c];
    end
  end

  always_comb begin
    read_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (addr[CH_BITS+1:2] == CH_BITS'(c)) begin
        case (addr[1:0])
          REG_CTRL:     read_data = {27'd0, pend_q[c], im_q[c], mode_q[c], en_q[c]};
          REG_PRESET:   read_data = 32'(preset_q[c]);
          REG_COUNT:    read_data = 32'(count_q[c]);
          REG_PRESCALE: read_data = 32'(prescale_q[c]);
          default:      read_data = '0;
        endcase
      end
    end
  end

  assign irq = pend_q & im_q;

  generate
    if (CNT_WIDTH < 32) begin : g_unused_wd
      logic unused_wd_hi;
      assign unused_wd_hi = ^write_data[31:CNT_WIDTH];
    end
  endgenerate

endmodule

// File: tb/tb_timer_bank.sv
// tb/tb_timer_bank.sv - self-checking bench for timer_bank with a period-arithmetic model
module tb_timer_bank;
  localparam int NUM_CH    = 3;
  localparam int CNT_WIDTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  addr = '0;
  logic        we = 1'b0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic [2:0]  irq;

  int n_cmp = 0;
  int n_bad = 0;

  timer_bank #(.NUM_CH(NUM_CH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk(clk), .reset(reset), .addr(addr), .we(we),
    .write_data(write_data), .read_data(read_data), .irq(irq)
  );

  always #5 clk = ~clk;

  // Edges from the enabling write to the expiry edge (PEND set).
  function automatic int period(int n, int p);
    return (n + 1) * (p + 1) + 1;
  endfunction

  // COUNT after the k-th edge following the enabling write (k >= 1).
  function automatic int exp_count(int n, int p, bit arl, int k);
    int t, m, d;
    t = period(n, p);
    if (!arl && k >= t) return 0;
    m = k % t;
    if (m == 0) return 0;
    d = (m - 1) / (p + 1);
    return (d < n) ? n - d : 0;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_write(int ch, int r, logic [31:0] d);
    addr = 4'(ch * 4 + r);
    write_data = d;
    we = 1'b1;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic rd(int ch, int r, output logic [31:0] v);
    addr = 4'(ch * 4 + r);
    #1;
    v = read_data;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    do_reset();
    for (int a = 0; a < 16; a++) begin
      rd(a / 4, a % 4, v);
      n_cmp++;
      if (v !== 32'd0) begin n_bad++; $display("FAIL reset_read addr=%0d got %0h exp 0", a, v); end
    end
    n_cmp++;
    if (irq !== 3'b000) begin n_bad++; $display("FAIL reset_irq got %b exp 000", irq); end
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    do_reset();
    do_write(0, 1, 32'd5);
    do_write(0, 3, 32'd0);
    do_write(0, 0, 32'h09);
    for (int k = 1; k <= 6; k++) begin
      step();
      rd(0, 2, v);
      n_cmp++;
      if (v !== 32'(6 - k)) begin n_bad++; $display("FAIL oneshot_count k=%0d got %0d exp %0d", k, v, 6 - k); end
    end
    n_cmp++;
    if (irq !== 3'b000) begin n_bad++; $display("FAIL oneshot_irq_early got %b exp 000", irq); end
    step();
    n_cmp++;
    if (irq !== 3'b001) begin n_bad++; $display("FAIL oneshot_irq got %b exp 001", irq); end
    rd(0, 0, v);
    n_cmp++;
    if (v !== 32'h18) begin n_bad++; $display("FAIL oneshot_ctrl got %0h exp 18", v); end
    do_write(0, 0, 32'h18);
    n_cmp++;
    if (irq !== 3'b000) begin n_bad++; $display("FAIL oneshot_clear_irq got %b exp 000", irq); end
    rd(0, 0, v);
    n_cmp++;
    if (v !== 32'h08) begin n_bad++; $display("FAIL oneshot_clear_ctrl got %0h exp 08", v); end
  endtask

  task automatic test_autoreload();
    logic [31:0] v;
    int k;
    do_reset();
    do_write(1, 1, 32'd3);
    do_write(1, 3, 32'd1);
    do_write(1, 0, 32'h0B);
    for (k = 1; k <= 20; k++) begin
      // Clear PEND on a quiet edge (10) and on the exact expiry edge (18).
      if (k == 10 || k == 18 || k == 19) do_write(1, 0, 32'h1B);
      else step();
      rd(1, 2, v);
      n_cmp++;
      if (v !== 32'(exp_count(3, 1, 1'b1, k))) begin
        n_bad++; $display("FAIL auto_count k=%0d got %0d exp %0d", k, v, exp_count(3, 1, 1'b1, k));
      end
      n_cmp++;
      if (irq[1] !== ((k >= 9 && k < 10) || (k == 18))) begin
        n_bad++; $display("FAIL auto_pend k=%0d got %b", k, irq[1]);
      end
    end
  endtask

  task automatic test_pause_resume();
    logic [31:0] v;
    do_reset();
    do_write(0, 1, 32'd100);
    do_write(0, 0, 32'h01);
    for (int k = 1; k <= 61; k++) begin
      step();
      rd(0, 2, v);
      n_cmp++;
      if (v !== 32'(101 - k)) begin n_bad++; $display("FAIL pause_run k=%0d got %0d exp %0d", k, v, 101 - k); end
    end
    do_write(0, 0, 32'h00);
    for (int k = 0; k < 12; k++) begin
      rd(0, 2, v);
      n_cmp++;
      if (v !== 32'd40) begin n_bad++; $display("FAIL pause_frozen i=%0d got %0d exp 40", k, v); end
      step();
    end
    do_write(0, 0, 32'h01);
    rd(0, 2, v);
    n_cmp++;
    if (v !== 32'd40) begin n_bad++; $display("FAIL resume_first got %0d exp 40", v); end
    step();
    rd(0, 2, v);
    n_cmp++;
    if (v !== 32'd39) begin n_bad++; $display("FAIL resume_next got %0d exp 39", v); end
    do_write(0, 0, 32'h21);
    step();
    rd(0, 2, v);
    n_cmp++;
    if (v !== 32'd100) begin n_bad++; $display("FAIL restart_reload got %0d exp 100", v); end
  endtask

  task automatic test_invalid_ch();
    logic [31:0] v;
    do_reset();
    for (int r = 0; r < 4; r++) do_write(3, r, 32'hFFFF_FFFF);
    for (int a = 0; a < 16; a++) begin
      rd(a / 4, a % 4, v);
      n_cmp++;
      if (v !== 32'd0) begin n_bad++; $display("FAIL invalid_ch addr=%0d got %0h exp 0", a, v); end
    end
    do_write(2, 1, 32'hABCD_1234);
    rd(2, 1, v);
    n_cmp++;
    if (v !== 32'h1234) begin n_bad++; $display("FAIL truncate got %0h exp 1234", v); end
    do_write(2, 0, 32'hFFFF_FFC8);
    rd(2, 0, v);
    n_cmp++;
    if (v !== 32'h08) begin n_bad++; $display("FAIL ctrl_bits got %0h exp 08", v); end
    do_write(2, 2, 32'h55);
    step();
    rd(2, 2, v);
    n_cmp++;
    if (v !== 32'd0) begin n_bad++; $display("FAIL count_ro got %0h exp 0", v); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    do_write(0, 1, 32'd4);
    do_write(2, 1, 32'd1);
    do_write(2, 3, 32'd1);
    do_write(0, 0, 32'h09);
    do_write(2, 0, 32'h09);
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) step();
      n_cmp++;
      if (irq !== ((k == 6) ? 3'b101 : 3'b000)) begin
        n_bad++; $display("FAIL simul_irq k=%0d got %b exp %b", k, irq, (k == 6) ? 3'b101 : 3'b000);
      end
    end
  endtask

  task automatic test_reset_midcount();
    logic [31:0] v;
    do_reset();
    do_write(0, 1, 32'd2);
    do_write(0, 0, 32'h0B);
    for (int k = 1; k <= 5; k++) step();
    n_cmp++;
    if (irq !== 3'b001) begin n_bad++; $display("FAIL midreset_pre got %b exp 001", irq); end
    do_reset();
    n_cmp++;
    if (irq !== 3'b000) begin n_bad++; $display("FAIL midreset_irq got %b exp 000", irq); end
    for (int a = 0; a < 12; a++) begin
      rd(a / 4, a % 4, v);
      n_cmp++;
      if (v !== 32'd0) begin n_bad++; $display("FAIL midreset_read addr=%0d got %0h exp 0", a, v); end
    end
    for (int k = 0; k < 4; k++) step();
    rd(0, 2, v);
    n_cmp++;
    if (v !== 32'd0 || irq !== 3'b000) begin
      n_bad++; $display("FAIL midreset_idle count=%0d irq=%b exp 0/000", v, irq);
    end
  endtask

  task automatic test_random();
    logic [31:0] v;
    int ch, n, p, md, im, t, ec, ectl;
    bit arl;
    for (int tr = 0; tr < 6; tr++) begin
      do_reset();
      ch = $urandom_range(0, 2);
      n  = $urandom_range(0, 10);
      p  = $urandom_range(0, 3);
      md = $urandom_range(0, 3);
      im = $urandom_range(0, 1);
      arl = (md == 1);
      t = period(n, p);
      do_write(ch, 1, (32'($urandom_range(0, 65535)) << 16) | 32'(n));
      do_write(ch, 3, 32'(p));
      do_write(ch, 0, 32'(1 | (md << 1) | (im << 3)));
      for (int k = 1; k <= 2 * t + 2; k++) begin
        step();
        ec = exp_count(n, p, arl, k);
        ectl = ((k >= t) ? 16 : 0) | (im << 3) | (md << 1) | ((arl || k < t) ? 1 : 0);
        rd(ch, 2, v);
        n_cmp++;
        if (v !== 32'(ec)) begin
          n_bad++; $display("FAIL rand_count tr=%0d ch=%0d n=%0d p=%0d md=%0d k=%0d got %0d exp %0d", tr, ch, n, p, md, k, v, ec);
        end
        rd(ch, 0, v);
        n_cmp++;
        if (v !== 32'(ectl)) begin
          n_bad++; $display("FAIL rand_ctrl tr=%0d k=%0d got %0h exp %0h", tr, k, v, ectl);
        end
        n_cmp++;
        if (irq !== ((k >= t && im == 1) ? 3'(1 << ch) : 3'b000)) begin
          n_bad++; $display("FAIL rand_irq tr=%0d k=%0d got %b", tr, k, irq);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_autoreload();
    test_pause_resume();
    test_invalid_ch();
    test_simultaneous();
    test_reset_midcount();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
